fp_mul_round_pack: RTL

//  Downstream stage of the single-precision FP multiplier. Consumes the raw 48-bit significand product,
//  the XORed sign and the 9-bit biased-exponent sum, then normalizes, rounds and checks the exponent

---
 rtl/fpm_pkg.sv | 22 ++
 rtl/fpm_round_rne.sv | 39 +++
 rtl/fp_mul_round_pack.sv | 119 +++++++++++
 3 files changed

// File: rtl/fpm_pkg.sv
// fpm_pkg: shared constants and the stage-1 pipeline record for the
// single-precision multiplier round/pack stage (fp_mul_round_pack).
package fpm_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;
  localparam int PRDT_W = 2 * (MANT_W + 1);
  localparam int SEXP_W = 11;
  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  // Normalized but not yet rounded value carried from S1 to S2.
  typedef struct packed {
    logic              sign;
    logic              zero;
    logic [SEXP_W-1:0] exp;
    logic [MANT_W-1:0] mant;
    logic              g;
    logic              st;
  } fpm_s1_t;

endpackage

// File: rtl/fpm_round_rne.sv
// fpm_round_rne: combinational mantissa rounding for the S2 stage.
// Build option FPM_RNE_ROUND_EN: defined -> round-to-nearest-even,
// undefined -> truncation (mantissa and exponent pass through).
module fpm_round_rne
  import fpm_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic              g,
  input  logic              st,
  input  logic [SEXP_W-1:0] exp,
  output logic [MANT_W-1:0] mant_rnd,
  output logic [SEXP_W-1:0] exp_rnd
);

`ifdef FPM_RNE_ROUND_EN
  logic              inc;
  logic [MANT_W:0]   sum;

  // Round half to even; a carry out of the mantissa bumps the exponent.
  always_comb begin
    inc      = g & (st | mant[0]);
    sum      = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
    mant_rnd = sum[MANT_W-1:0];
    exp_rnd  = exp;
    if (sum[MANT_W]) begin
      mant_rnd = '0;
      exp_rnd  = exp + SEXP_W'(1);
    end
  end
`else
  logic unused_rnd_bits;

  // Truncation: guard/sticky only feed the inexact flag upstream.
  assign unused_rnd_bits = g | st;
  assign mant_rnd        = mant;
  assign exp_rnd         = exp;
`endif

endmodule

// File: rtl/fp_mul_round_pack.sv
// fp_mul_round_pack: normalize (S1), round and range-check/pack (S2) the raw
// 24x24 significand product into an IEEE-754 binary32 result.
// Rounding mode selected by FPM_RNE_ROUND_EN (see fpm_round_rne).
//
// Handshake: a transfer occurs on a rising edge where valid and ready are both
// high. Each stage loads when it is empty or the stage after it is advancing,
// so in_ready = !s1_valid | !out_valid | out_ready, forced low during reset.
// Under backpressure the output registers hold their value.
module fp_mul_round_pack
  import fpm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W:0]    in_exp_sum,
  input  logic [PRDT_W-1:0] in_prdt,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              out_inexact
);

  localparam logic [SEXP_W-1:0] EXP_MAX = {3'b000, EXP_INF};

  logic              s1_valid;
  fpm_s1_t           s1_q;
  fpm_s1_t           s1_d;
  logic              s1_load;
  logic              s2_load;
  logic [MANT_W-1:0] mant_rnd;
  logic [SEXP_W-1:0] exp_rnd;
  logic [31:0]       res_d;
  logic              ovf_d;
  logic              unf_d;
  logic              inx_d;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !rst && s1_load;

  // S1 normalize: the product is in [1,4); bit 47 selects the one-bit shift.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    s1_d.zero = in_zero;
    if (in_prdt[PRDT_W-1]) begin
      s1_d.mant = in_prdt[PRDT_W-2:PRDT_W-1-MANT_W];
      s1_d.g    = in_prdt[PRDT_W-2-MANT_W];
      s1_d.st   = |in_prdt[PRDT_W-3-MANT_W:0];
    end else begin
      s1_d.mant = in_prdt[PRDT_W-3:PRDT_W-2-MANT_W];
      s1_d.g    = in_prdt[PRDT_W-3-MANT_W];
      s1_d.st   = |in_prdt[PRDT_W-4-MANT_W:0];
    end
    s1_d.exp = {2'b00, in_exp_sum} - SEXP_W'(BIAS)
             + {{(SEXP_W-1){1'b0}}, in_prdt[PRDT_W-1]};
  end

  // S1 pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      s1_q     <= s1_d;
    end
  end

  fpm_round_rne u_round (
    .mant     (s1_q.mant),
    .g        (s1_q.g),
    .st       (s1_q.st),
    .exp      (s1_q.exp),
    .mant_rnd (mant_rnd),
    .exp_rnd  (exp_rnd)
  );

  // S2 range check in priority order: zero, overflow, underflow, normal.
  always_comb begin
    res_d = {s1_q.sign, 31'd0};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = s1_q.g | s1_q.st;
    if (s1_q.zero) begin
      inx_d = 1'b0;
    end else if ($signed(exp_rnd) >= $signed(EXP_MAX)) begin
      res_d = {s1_q.sign, EXP_INF, {MANT_W{1'b0}}};
      ovf_d = 1'b1;
    end else if ($signed(exp_rnd) <= $signed(SEXP_W'(0))) begin
      unf_d = 1'b1;
    end else begin
      res_d = {s1_q.sign, exp_rnd[EXP_W-1:0], mant_rnd};
    end
  end

  // S2 output register: result and flags advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (s2_load) begin
      out_valid     <= s1_valid;
      out_result    <= res_d;
      out_overflow  <= ovf_d;
      out_underflow <= unf_d;
      out_inexact   <= inx_d;
    end
  end

endmodule
